// File: rtl/pc_redirect_pkg.sv
// Shared constants and state encoding for the fetch-PC redirect logic.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
package pc_redirect_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int INST_BYTES   = 4;
  localparam int FCNT_W       = 3;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_FLUSH = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_branch_stats_counter.sv
// Saturating event counter used for the optional branch statistics (BRANCH_STATS_EN).
module branch_stats_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Sticks at all-ones rather than wrapping so overflow is visible.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC register: applies the Execute-stage branch decision, redirects and flushes.
// Define BRANCH_STATS_EN to add saturating branch total/taken counters.
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter int                XLEN         = DEFAULT_XLEN,
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            valid_de,
  input  logic            is_branch_de,
  input  logic            jump_state_pre,
  input  logic [XLEN-1:0] target_de,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     br_total_cnt,
  output logic [31:0]     br_taken_cnt,
`endif
  output logic [XLEN-1:0] pc_if,
  output logic            redirect,
  output logic            flush,
  output logic            misalign
);

  pc_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              redirect_q, redirect_d;
  logic              misalign_q, misalign_d;
  logic              take;
  logic              aligned;

  // Case-equality keeps an X/Z comparator result from ever being treated as taken.
  assign take    = valid_de & is_branch_de & (jump_state_pre === 1'b1) & ~stall
                   & (state_q == PC_RUN);
  assign aligned = (target_de[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fcnt_d     = fcnt_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    if (!stall) begin
      case (state_q)
        PC_RUN: begin
          if (take && aligned) begin
            pc_d       = target_de;
            redirect_d = 1'b1;
            fcnt_d     = FCNT_W'(FLUSH_CYCLES - 1);
            state_d    = PC_FLUSH;
          end else if (take) begin
            misalign_d = 1'b1;
          end else begin
            pc_d = pc_q + XLEN'(INST_BYTES);
          end
        end
        PC_FLUSH: begin
          pc_d = pc_q + XLEN'(INST_BYTES);
          if (fcnt_q == '0) begin
            state_d = PC_RUN;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end
        default: state_d = PC_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PC_RUN;
      pc_q       <= RESET_VECTOR;
      fcnt_q     <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fcnt_q     <= fcnt_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_if    = pc_q;
  assign redirect = redirect_q;
  assign flush    = (state_q == PC_FLUSH);
  assign misalign = misalign_q;

`ifdef BRANCH_STATS_EN
  logic br_seen;
  assign br_seen = valid_de & is_branch_de & ~stall & (state_q == PC_RUN);

  branch_stats_counter #(.W(32)) u_total_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (br_seen),
    .count_o (br_total_cnt)
  );

  branch_stats_counter #(.W(32)) u_taken_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (take & aligned),
    .count_o (br_taken_cnt)
  );
`endif

endmodule

// File: tb/tb_pc_redirect.sv
// Directed self-checking bench for pc_redirect (stats checks only when BRANCH_STATS_EN is defined).
module tb_pc_redirect;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        valid_de;
  logic        is_branch_de;
  logic        jump_state_pre;
  logic [31:0] target_de;
  logic [31:0] pc_if;
  logic        redirect;
  logic        flush;
  logic        misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_cnt;
  logic [31:0] br_taken_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pc_redirect #(.XLEN(32), .FLUSH_CYCLES(2), .RESET_VECTOR(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .valid_de       (valid_de),
    .is_branch_de   (is_branch_de),
    .jump_state_pre (jump_state_pre),
    .target_de      (target_de),
`ifdef BRANCH_STATS_EN
    .br_total_cnt   (br_total_cnt),
    .br_taken_cnt   (br_taken_cnt),
`endif
    .pc_if          (pc_if),
    .redirect       (redirect),
    .flush          (flush),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and sample 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_branch(input logic v, input logic jsp, input logic [31:0] tgt);
    valid_de       = v;
    is_branch_de   = v;
    jump_state_pre = jsp;
    target_de      = tgt;
  endtask

  task automatic check_outs(input string name, input logic [31:0] epc, input logic ered,
                            input logic efl, input logic emis);
    checks++;
    if (pc_if !== epc || redirect !== ered || flush !== efl || misalign !== emis) begin
      errors++;
      $display("[TB] FAIL %s: got pc=%h red=%b fl=%b mis=%b, expected pc=%h red=%b fl=%b mis=%b",
               name, pc_if, redirect, flush, misalign, epc, ered, efl, emis);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    set_branch(1'b0, 1'b0, 32'h0);
    #12;
    checks++;
    if (pc_if !== 32'h0 || flush !== 1'b0 || redirect !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: got pc=%h fl=%b red=%b mis=%b, expected 0", pc_if, flush,
               redirect, misalign);
    end
`ifdef BRANCH_STATS_EN
    checks++;
    if (br_total_cnt !== 32'd0 || br_taken_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got total=%0d taken=%0d, expected 0 0", br_total_cnt,
               br_taken_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    check_outs("seq0", exp_pc[0], 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step();
      check_outs($sformatf("seq%0d", i), exp_pc[i], 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_taken();
    set_branch(1'b1, 1'b1, 32'h100);
    step();
    check_outs("taken_redirect", 32'h100, 1'b1, 1'b1, 1'b0);
    set_branch(1'b0, 1'b0, 32'h0);
    step();
    check_outs("taken_flush2", 32'h104, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("taken_done", 32'h108, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_not_taken();
    set_branch(1'b1, 1'b0, 32'h400);
    step();
    check_outs("not_taken", 32'h10C, 1'b0, 1'b0, 1'b0);
    set_branch(1'b1, 1'bx, 32'h400);
    step();
    check_outs("jsp_x", 32'h110, 1'b0, 1'b0, 1'b0);
    set_branch(1'b1, 1'bz, 32'h400);
    step();
    check_outs("jsp_z", 32'h114, 1'b0, 1'b0, 1'b0);
    set_branch(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_misalign();
    set_branch(1'b1, 1'b1, 32'h102);
    step();
    check_outs("misalign_pulse", 32'h114, 1'b0, 1'b0, 1'b1);
    set_branch(1'b0, 1'b0, 32'h0);
    step();
    check_outs("misalign_clear", 32'h118, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_flush();
    set_branch(1'b1, 1'b1, 32'h200);
    step();
    check_outs("stall_redirect", 32'h200, 1'b1, 1'b1, 1'b0);
    set_branch(1'b0, 1'b0, 32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("stall_hold%0d", i), 32'h200, 1'b0, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    check_outs("stall_flush_last", 32'h204, 1'b0, 1'b1, 1'b0);
    step();
    check_outs("stall_flush_end", 32'h208, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_ignore_and_reset();
    set_branch(1'b1, 1'b1, 32'h300);
    step();
    check_outs("second_redirect", 32'h300, 1'b1, 1'b1, 1'b0);
    set_branch(1'b1, 1'b1, 32'h400);
    step();
    check_outs("flush_ignores_branch", 32'h304, 1'b0, 1'b1, 1'b0);
    set_branch(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_outs("reset_mid_flush", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_outs("after_reset", 32'h4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall_run();
    stall = 1'b1;
    set_branch(1'b1, 1'b1, 32'h500);
    step();
    check_outs("run_stall_hold", 32'h4, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    set_branch(1'b0, 1'b0, 32'h0);
    step();
    check_outs("run_stall_release", 32'h8, 1'b0, 1'b0, 1'b0);
    // Wrap-around from the top of the address space.
    set_branch(1'b1, 1'b1, 32'hFFFF_FFF8);
    step();
    set_branch(1'b0, 1'b0, 32'h0);
    step();
    step();
    check_outs("wrap_top", 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    set_branch(1'b1, 1'b0, 32'h40);
    step();
    set_branch(1'b1, 1'b1, 32'h40);
    step();
    set_branch(1'b1, 1'b1, 32'h80);
    step();
    step();
    set_branch(1'b1, 1'b0, 32'h80);
    step();
    set_branch(1'b0, 1'b0, 32'h0);
    checks++;
    if (br_total_cnt !== 32'd3 || br_taken_cnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL stats: got total=%0d taken=%0d, expected total=3 taken=1",
               br_total_cnt, br_taken_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_taken();
    test_not_taken();
    test_misalign();
    test_stall_flush();
    test_flush_ignore_and_reset();
    test_stall_run();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
